// File: rtl/cp0_timer_int_unit_if.sv
// CP0 side-band bus between the register file and the timer/interrupt unit:
// mtc0 write strobe, Status gating bits in, timer/interrupt state out.
interface cp0_timer_int_unit_if;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [31:0] wr_data;
    logic        status_ie;
    logic        status_exl;
    logic        status_erl;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [7:0]  status_im_o;
    logic [7:0]  cause_ip_o;
    logic        cause_ti_o;
    logic        int_req;

    modport master (
        output wr_en, wr_sel, wr_data, status_ie, status_exl, status_erl,
        input  count_o, compare_o, status_im_o, cause_ip_o, cause_ti_o, int_req
    );

    modport slave (
        input  wr_en, wr_sel, wr_data, status_ie, status_exl, status_erl,
        output count_o, compare_o, status_im_o, cause_ip_o, cause_ti_o, int_req
    );
endinterface

// File: rtl/cp0_timer_int_unit.sv
// Count/Compare timer with prescaler, sticky Cause.TI, Cause.IP/Status.IM
// ownership, hw_int synchronisers and a registered interrupt request.
module cp0_timer_int_unit #(
    parameter int DIV         = 2,
    parameter int NUM_HW_INT  = 6,
    parameter int SYNC_STAGES = 2,
    parameter int TIMER_IP    = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_HW_INT-1:0] hw_int,
    cp0_timer_int_unit_if.slave   bus
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0]         presc;
    logic                  tick;
    logic [31:0]           count;
    logic [31:0]           compare;
    logic                  ti;
    logic [1:0]            ip_sw;
    logic [7:0]            im;
    logic [7:0]            ip;
    logic                  int_req_q;
    logic [NUM_HW_INT-1:0] sync_q [SYNC_STAGES];

    logic wr_count;
    logic wr_compare;
    logic wr_im;
    logic wr_ipsw;

    assign wr_count   = bus.wr_en && (bus.wr_sel == 2'd0);
    assign wr_compare = bus.wr_en && (bus.wr_sel == 2'd1);
    assign wr_im      = bus.wr_en && (bus.wr_sel == 2'd2);
    assign wr_ipsw    = bus.wr_en && (bus.wr_sel == 2'd3);

    // With DIV=1 the prescaler is stuck at 0 and this fires every cycle.
    assign tick = (presc == PW'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            count <= '0;
        end else if (wr_count) begin
            presc <= '0;
            count <= bus.wr_data;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick)
                count <= count + 32'd1;
        end
    end

    // A Compare write clears TI and beats a match seen in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            compare <= 32'hFFFF_FFFF;
            ti      <= 1'b0;
        end else if (wr_compare) begin
            compare <= bus.wr_data;
            ti      <= 1'b0;
        end else if (count == compare) begin
            ti      <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            im    <= '0;
            ip_sw <= '0;
        end else begin
            if (wr_im)
                im <= bus.wr_data[15:8];
            if (wr_ipsw)
                ip_sw <= bus.wr_data[9:8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SYNC_STAGES; s++)
                sync_q[s] <= '0;
        end else begin
            sync_q[0] <= hw_int;
            for (int s = 1; s < SYNC_STAGES; s++)
                sync_q[s] <= sync_q[s-1];
        end
    end

    always_comb begin
        ip       = '0;
        ip[1:0]  = ip_sw;
        for (int i = 0; i < NUM_HW_INT; i++)
            ip[2+i] = sync_q[SYNC_STAGES-1][i];
        ip[TIMER_IP] = ip[TIMER_IP] | ti;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            int_req_q <= 1'b0;
        else
            int_req_q <= bus.status_ie & ~bus.status_exl & ~bus.status_erl & (|(ip & im));
    end

    assign bus.count_o     = count;
    assign bus.compare_o   = compare;
    assign bus.status_im_o = im;
    assign bus.cause_ip_o  = ip;
    assign bus.cause_ti_o  = ti;
    assign bus.int_req     = int_req_q;

endmodule

// File: tb/tb_cp0_timer_int_unit.sv
// Directed scoreboard bench for cp0_timer_int_unit (DIV=2, 6 hw lines, 2 sync stages, TI on IP[7]).
module tb_cp0_timer_int_unit;

    localparam int F_COUNT = 0, F_COMPARE = 1, F_IM = 2, F_IP = 3, F_TI = 4, F_INT = 5;

    typedef struct {
        int          cyc;
        int          fld;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] hw_int;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];
    exp_t       keep[$];

    cp0_timer_int_unit_if bus();

    cp0_timer_int_unit #(
        .DIV(2), .NUM_HW_INT(6), .SYNC_STAGES(2), .TIMER_IP(7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hw_int(hw_int),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int f);
        case (f)
            F_COUNT:   return bus.count_o;
            F_COMPARE: return bus.compare_o;
            F_IM:      return {24'd0, bus.status_im_o};
            F_IP:      return {24'd0, bus.cause_ip_o};
            F_TI:      return {31'd0, bus.cause_ti_o};
            default:   return {31'd0, bus.int_req};
        endcase
    endfunction

    // Monitor: compare every expectation that falls due in the current cycle.
    always @(negedge clk) begin
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                if (actual(sb[i].fld) !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", sb[i].name, cyc,
                             actual(sb[i].fld), sb[i].val);
                end
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    task automatic chk_at(input int d, input int f, input logic [31:0] v, input string n);
        exp_t e;
        e.cyc  = cyc + d;
        e.fld  = f;
        e.val  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] s, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = s;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        hw_int         = '0;
        bus.wr_en      = 1'b0;
        bus.wr_sel     = '0;
        bus.wr_data    = '0;
        bus.status_ie  = 1'b0;
        bus.status_exl = 1'b0;
        bus.status_erl = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        checks++;
        if (bus.count_o !== 32'h0) begin
            errors++;
            $display("FAIL inl_rst_count got=%h", bus.count_o);
        end
        checks++;
        if (bus.compare_o !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL inl_rst_compare got=%h", bus.compare_o);
        end
        checks++;
        if (bus.status_im_o !== 8'h0) begin
            errors++;
            $display("FAIL inl_rst_im got=%h", bus.status_im_o);
        end
        checks++;
        if (bus.int_req !== 1'b0) begin
            errors++;
            $display("FAIL inl_rst_int_req got=%b", bus.int_req);
        end
        chk_at(0, F_COUNT,   32'h0,         "rst_count");
        chk_at(0, F_COMPARE, 32'hFFFF_FFFF, "rst_compare");
        chk_at(0, F_IM,      32'h0,         "rst_im");
        chk_at(0, F_IP,      32'h0,         "rst_ip");
        chk_at(0, F_TI,      32'h0,         "rst_ti");
        chk_at(0, F_INT,     32'h0,         "rst_int_req");
        step();

        // Prescaler DIV=2: Count holds two cycles per value.
        wr(2'd0, 32'd5);
        chk_at(0, F_COUNT, 32'd5, "div_c0");
        chk_at(1, F_COUNT, 32'd5, "div_c1");
        chk_at(2, F_COUNT, 32'd6, "div_c2");
        chk_at(3, F_COUNT, 32'd6, "div_c3");
        chk_at(4, F_COUNT, 32'd7, "div_c4");
        chk_at(5, F_COUNT, 32'd7, "div_c5");
        repeat (5) step();

        // Wrap; Count meets the reset Compare value so TI also sets.
        wr(2'd0, 32'hFFFF_FFFF);
        chk_at(0, F_COUNT, 32'hFFFF_FFFF, "wrap_c0");
        chk_at(0, F_TI,    32'h0,         "wrap_ti0");
        chk_at(1, F_COUNT, 32'hFFFF_FFFF, "wrap_c1");
        chk_at(1, F_TI,    32'h1,         "wrap_ti1");
        chk_at(1, F_IP,    32'h80,        "wrap_ip");
        chk_at(2, F_COUNT, 32'h0,         "wrap_c2");
        chk_at(2, F_INT,   32'h0,         "wrap_int_masked");
        repeat (2) step();

        // Timer interrupt.
        wr(2'd1, 32'd8);
        chk_at(0, F_TI, 32'h0, "cmp_wr_clears_ti");
        bus.status_ie = 1'b1;
        wr(2'd2, 32'h0000_8000);
        chk_at(0, F_IM, 32'h80, "im_80");
        wr(2'd0, 32'd6);
        chk_at(4, F_COUNT, 32'd8, "tmr_count8");
        chk_at(4, F_TI,    32'h0, "tmr_ti_before");
        chk_at(5, F_TI,    32'h1, "tmr_ti_set");
        chk_at(5, F_INT,   32'h0, "tmr_int_lat");
        chk_at(6, F_INT,   32'h1, "tmr_int_req");
        chk_at(6, F_TI,    32'h1, "tmr_ti_sticky");
        repeat (6) step();
        wr(2'd1, 32'h20);
        chk_at(0, F_TI,  32'h0, "tmr_ti_clr");
        chk_at(0, F_INT, 32'h1, "tmr_int_hold");
        chk_at(1, F_INT, 32'h0, "tmr_int_clr");
        step();

        // Compare write in the same cycle as a match.
        wr(2'd1, 32'h40);
        wr(2'd0, 32'h40);
        wr(2'd1, 32'h50);
        chk_at(0, F_COMPARE, 32'h50, "col_compare");
        chk_at(0, F_TI,      32'h0,  "col_ti0");
        chk_at(1, F_TI,      32'h0,  "col_ti1");
        chk_at(1, F_INT,     32'h0,  "col_int");
        repeat (2) step();
        wr(2'd1, 32'hFFFF_0000);

        // Hardware interrupt through the synchroniser.
        wr(2'd2, 32'h0000_0400);
        hw_int[0] = 1'b1;
        chk_at(1, F_IP,  32'h00, "hw_ip_d1");
        chk_at(2, F_IP,  32'h04, "hw_ip_d2");
        chk_at(2, F_INT, 32'h0,  "hw_int_d2");
        chk_at(3, F_INT, 32'h1,  "hw_int_d3");
        repeat (3) step();
        hw_int[0] = 1'b0;
        chk_at(2, F_IP,  32'h00, "hw_ip_fall");
        chk_at(3, F_INT, 32'h0,  "hw_int_fall");
        repeat (3) step();
        bus.status_exl = 1'b1;
        hw_int[0] = 1'b1;
        chk_at(2, F_IP,  32'h04, "exl_ip");
        chk_at(3, F_INT, 32'h0,  "exl_int_d3");
        chk_at(4, F_INT, 32'h0,  "exl_int_d4");
        repeat (4) step();
        hw_int[0] = 1'b0;
        repeat (3) step();
        bus.status_exl = 1'b0;

        // Software interrupt IP[0], gated by ERL.
        wr(2'd2, 32'h0000_0100);
        wr(2'd3, 32'h0000_0100);
        chk_at(0, F_IP,  32'h01, "sw_ip");
        chk_at(0, F_INT, 32'h0,  "sw_int_d0");
        chk_at(1, F_INT, 32'h1,  "sw_int_d1");
        step();
        bus.status_erl = 1'b1;
        chk_at(1, F_INT, 32'h0, "erl_int");
        step();
        bus.status_erl = 1'b0;
        chk_at(1, F_INT, 32'h1, "erl_release");
        step();
        wr(2'd3, 32'h0);
        chk_at(0, F_IP,  32'h00, "sw_ip_clr");
        chk_at(0, F_INT, 32'h1,  "sw_int_hold");
        chk_at(1, F_INT, 32'h0,  "sw_int_clr");
        step();

        // Asynchronous reset in the middle of counting.
        wr(2'd0, 32'h10);
        chk_at(0, F_COUNT, 32'h10, "pre_rst_count");
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.count_o !== 32'h0) begin
            errors++;
            $display("FAIL inl_arst_count got=%h", bus.count_o);
        end
        checks++;
        if (bus.compare_o !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL inl_arst_compare got=%h", bus.compare_o);
        end
        chk_at(0, F_COUNT,   32'h0,         "arst_count");
        chk_at(0, F_COMPARE, 32'hFFFF_FFFF, "arst_compare");
        chk_at(0, F_IM,      32'h0,         "arst_im");
        chk_at(0, F_INT,     32'h0,         "arst_int_req");
        repeat (2) step();
        rst = 1'b1;

        repeat (3) step();
        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s never_checked due=%0d now=%0d", sb[i].name, sb[i].cyc, cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
